row_clear: RTL
==============

Name: row_clear

Overview:
- Sits directly downstream of the top-contact/merge stage in Simplified Tetris.
- Triggered when a falling block lands and has been merged into the heap columns (c1_t..c8_t).
- Scans the merged heap bottom-up, removes every completely filled row, and shifts the rows above it down by one.
- Returns the cleaned heap plus per-drop and running cleared-line counts for the score display.

Parameters:
- ACTIVE_COLS, 7: number of playfield columns taking part in the full-row test and the shift (1..8). Columns with a higher index pass through unchanged.

Ports:
- clock  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse: merged heap on c*_in is valid; begin a clear pass
- c1_in..c8_in  input  36 each  merged heap columns; column n is screen x = 10*(n-1)
- c1_out..c8_out  output  36 each  heap after the clear pass (registered)
- busy  output  1  clear pass in progress
- done  output  1  one-cycle pulse; c*_out, lines_cleared and score are valid
- lines_cleared  output  4  rows removed in the last pass
- score  output  16  running total, saturating

Behaviour:
- Column format: 12 cells of 3-bit colour. Row k (k=0 is top, y=0; k=11 is bottom, y=110) occupies bits [35-3k : 33-3k]. Colour 000 means empty.
- Reset, synchronous, when resetn=0 at a clock edge:
  - all c*_out = 0, busy = 0, done = 0, lines_cleared = 0, score = 0
  - internal column registers = 0, row pointer = 11, FSM = IDLE
  - Reset takes priority over everything, including mid-pass; the abandoned pass produces no done.
- FSM states: IDLE, SCAN, SHIFT.
- IDLE:
  - done is cleared after its one cycle.
  - When start=1: latch c1_in..c8_in into the working registers, set r=11, busy<=1, go to SCAN.
- SCAN, row r:
  - Row is full when cell r is non-zero in every column 1..ACTIVE_COLS.
  - Full row: go to SHIFT.
  - Not full and r>0: r<=r-1, stay in SCAN.
  - Not full and r==0 (end of pass), all at one edge:
    - c*_out <= working registers
    - lines_cleared <= count
    - score <= score + increment, saturating at 16'hFFFF
    - done <= 1, busy <= 0, state <= IDLE
- SHIFT:
  - In each active column, cells 0..r-1 move to 1..r and cell 0 becomes 000; cells below r are untouched.
  - count <= count + 1, saturating at 15.
  - Return to SCAN with r unchanged, so the row that dropped into r is re-tested.
- Latency, from the start-sampling edge to done high: 12 + 2k cycles, where k = rows cleared. Maximum 36 cycles.
- start while busy=1 is ignored; no queuing.
- start in the same cycle done is high is accepted, because the FSM is already in IDLE.
- Columns above ACTIVE_COLS are copied from input to output unchanged.
- Contents of row 0 after a shift are always 000.
- c*_out hold their value between passes. done is never high while busy is high.

Optional Feature:
- Macro: ROW_CLEAR_BONUS_EN.
- Defined: score increment per pass comes from lines_cleared: 0->0, 1->1, 2->3, 3->5, >=4->8.
- Undefined: score increment = lines_cleared.
- Saturation and timing are identical in both builds.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles after random activity -> all c*_out=0, score=0, busy=0, done=0.
2. No full row: every active column has row 11 = 001 except c4 = 0 -> done exactly 12 cycles after start, c*_out == c*_in, lines_cleared=0, score unchanged.
3. Bottom row full: c1..c7 all 36'h1, and c1[5:3]=010 -> done at 14 cycles; c1_out=36'h2, c2_out..c7_out=0, lines_cleared=1, score=1.
4. Rows 11 and 9 full in c1..c7, row 10 holding 011 in c2 only -> done at 16 cycles; c2_out bottom cell = 011 and all else 0, lines_cleared=2. Score +2 without the macro, +3 with ROW_CLEAR_BONUS_EN.
5. ACTIVE_COLS=7, c8_in=36'hFFF, rows full in c1..c7 -> rows clear regardless of c8; c8_out=36'hFFF.
6. start pulsed at cycle 5 of a pass -> ignored, single done. Separately, resetn=0 at cycle 3 of a pass -> busy=0, no done, outputs 0; the next start completes normally.

Source files
------------

// File: rtl/row_clear.sv
// rtl/row_clear.sv - removes full heap rows bottom-up and tallies cleared lines
// Optional macro ROW_CLEAR_BONUS_EN selects the tiered score increment.
module row_clear #(
    parameter int ACTIVE_COLS = 7
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [35:0] c1_in,
    input  logic [35:0] c2_in,
    input  logic [35:0] c3_in,
    input  logic [35:0] c4_in,
    input  logic [35:0] c5_in,
    input  logic [35:0] c6_in,
    input  logic [35:0] c7_in,
    input  logic [35:0] c8_in,
    output logic [35:0] c1_out,
    output logic [35:0] c2_out,
    output logic [35:0] c3_out,
    output logic [35:0] c4_out,
    output logic [35:0] c5_out,
    output logic [35:0] c6_out,
    output logic [35:0] c7_out,
    output logic [35:0] c8_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  lines_cleared,
    output logic [15:0] score
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  lines_q, lines_d;
    logic [15:0] score_q, score_d;
    logic [35:0] work_q [8];
    logic [35:0] work_d [8];
    logic [35:0] out_q  [8];
    logic [35:0] out_d  [8];
    logic [35:0] in_cols [8];
    logic        row_full;
    logic [16:0] score_sum;

    // Row k sits at bits [35-3k -: 3]; row 0 is the top of the screen.
    function automatic logic [2:0] cell_at(input logic [35:0] col, input logic [3:0] r);
        int idx;
        idx = 35 - 3 * int'(r);
        return col[idx -: 3];
    endfunction

    // Cells 0..r-1 drop by one, the top cell empties, cells below r stay put.
    function automatic logic [35:0] shift_col(input logic [35:0] col, input logic [3:0] r);
        logic [35:0] res;
        res = col;
        for (int j = 0; j < 12; j++) begin
            if (j == 0)
                res[35 -: 3] = 3'b000;
            else if (j <= int'(r))
                res[35 - 3 * j -: 3] = col[35 - 3 * (j - 1) -: 3];
        end
        return res;
    endfunction

    function automatic logic [15:0] score_inc(input logic [3:0] n);
`ifdef ROW_CLEAR_BONUS_EN
        case (n)
            4'd0:    return 16'd0;
            4'd1:    return 16'd1;
            4'd2:    return 16'd3;
            4'd3:    return 16'd5;
            default: return 16'd8;
        endcase
`else
        return {12'd0, n};
`endif
    endfunction

    always_comb begin
        in_cols[0] = c1_in;
        in_cols[1] = c2_in;
        in_cols[2] = c3_in;
        in_cols[3] = c4_in;
        in_cols[4] = c5_in;
        in_cols[5] = c6_in;
        in_cols[6] = c7_in;
        in_cols[7] = c8_in;
    end

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < ACTIVE_COLS && cell_at(work_q[c], row_q) == 3'b000)
                row_full = 1'b0;
        end
    end

    assign score_sum = {1'b0, score_q} + {1'b0, score_inc(count_q)};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lines_d = lines_q;
        score_d = score_q;
        for (int c = 0; c < 8; c++) begin
            work_d[c] = work_q[c];
            out_d[c]  = out_q[c];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int c = 0; c < 8; c++)
                        work_d[c] = in_cols[c];
                    row_d   = 4'd11;
                    count_d = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (row_full) begin
                    state_d = S_SHIFT;
                end else if (row_q != 4'd0) begin
                    row_d = row_q - 4'd1;
                end else begin
                    for (int c = 0; c < 8; c++)
                        out_d[c] = work_q[c];
                    lines_d = count_q;
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                for (int c = 0; c < 8; c++) begin
                    if (c < ACTIVE_COLS)
                        work_d[c] = shift_col(work_q[c], row_q);
                end
                count_d = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
                // r stays put so whatever fell into it gets re-tested.
                state_d = S_SCAN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            row_q   <= 4'd11;
            count_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= 4'd0;
            score_q <= 16'd0;
            for (int c = 0; c < 8; c++) begin
                work_q[c] <= 36'd0;
                out_q[c]  <= 36'd0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lines_q <= lines_d;
            score_q <= score_d;
            for (int c = 0; c < 8; c++) begin
                work_q[c] <= work_d[c];
                out_q[c]  <= out_d[c];
            end
        end
    end

    assign c1_out        = out_q[0];
    assign c2_out        = out_q[1];
    assign c3_out        = out_q[2];
    assign c4_out        = out_q[3];
    assign c5_out        = out_q[4];
    assign c6_out        = out_q[5];
    assign c7_out        = out_q[6];
    assign c8_out        = out_q[7];
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign score         = score_q;

endmodule
